// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between a requester (master) and the divider (slave).
interface div_unit_if import div_unit_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    // start is only accepted while busy is low; done is a one-cycle pulse and
    // quotient/remainder/div_zero stay valid from that pulse until the next one.
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The shifted remainder can reach 2*divisor-1, so the compare needs one extra bit;
    // when it succeeds the difference is below the divisor and fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[WIDTH-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider with MIPS DIV/DIVU semantics, one quotient bit per cycle.
module div_unit import div_unit_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus,
    output div_state_t dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] orig_reg;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r, zero_flag;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             last_step;
    logic [WIDTH-1:0] q_mag;
    logic             dividend_neg, divisor_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (a_reg[WIDTH-1]),
        .divisor (b_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // a_reg starts as the dividend magnitude and fills with quotient bits from the right.
    assign q_mag        = {a_reg[WIDTH-2:0], q_bit};
    assign last_step    = (state == CALC) && (count == CW'(WIDTH - 1));
    assign dividend_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign divisor_neg  = bus.is_signed & bus.divisor[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            rem_reg       <= '0;
            orig_reg      <= '0;
            count         <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            zero_flag     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= dividend_neg ? -bus.dividend : bus.dividend;
                        b_reg     <= divisor_neg  ? -bus.divisor  : bus.divisor;
                        rem_reg   <= '0;
                        orig_reg  <= bus.dividend;
                        count     <= '0;
                        neg_q     <= dividend_neg ^ divisor_neg;
                        neg_r     <= dividend_neg;
                        zero_flag <= (bus.divisor == '0);
                    end
                end
                CALC: begin
                    a_reg   <= q_mag;
                    rem_reg <= rem_next;
                    count   <= count + CW'(1);
                    if (last_step) begin
                        // Divide-by-zero wins over the sign fix-up.
                        quotient_reg  <= zero_flag ? '1 : (neg_q ? -q_mag : q_mag);
                        remainder_reg <= zero_flag ? orig_reg : (neg_r ? -rem_next : rem_next);
                        div_zero_reg  <= zero_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
    assign dbg_state     = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, sign handling, overflow, divide-by-zero, busy-start and reset abort.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  div_state_t dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  logic       busy_ok;
  int         done_seen;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for the start edge, then scramble the operand inputs.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = 1'($urandom_range(0, 1));
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  // Counts cycles from the start edge (cycle 1 follows it) until done, bounded.
  task automatic wait_done(input int from, output int cyc, output logic b_ok);
    cyc  = from;
    b_ok = 1'b1;
    while (!bus.done && cyc < 80) begin
      if (!bus.busy) b_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.busy) b_ok = 1'b0;
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_q, input logic [W-1:0] exp_r, input logic exp_z);
    int   c;
    logic bo;
    launch(s, a, b);
    wait_done(1, c, bo);
    check({tag, "_lat"},  W'(c), 33);
    check({tag, "_busy"}, W'(bo), 1);
    check({tag, "_q"},    bus.quotient, exp_q);
    check({tag, "_r"},    bus.remainder, exp_r);
    check({tag, "_dz"},   W'(bus.div_zero), W'(exp_z));
    @(posedge clk);
    #1;
    check({tag, "_idle"}, W'({bus.busy, bus.done}), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // reset state
    #12;
    check("rst_q",     bus.quotient, 0);
    check("rst_r",     bus.remainder, 0);
    check("rst_flags", W'({bus.busy, bus.done, bus.div_zero}), 0);
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    run("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", bus.quotient, 32'd14);
    check("hold_r", bus.remainder, 32'd2);

    run("s_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("s_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run("s_m7_m2",   1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0);
    run("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    run("u_ovf",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run("s_div0",    1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);
    run("u_div0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);
    run("u_big",     1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

    // start with new operands 10 cycles into CALC must be ignored
    launch(1'b0, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend  = 32'd7;
    bus.divisor   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(11, lat, busy_ok);
    check("ign_lat",  W'(lat), 33);
    check("ign_busy", W'(busy_ok), 1);
    check("ign_q",    bus.quotient, 32'd142);
    check("ign_r",    bus.remainder, 32'd6);

    // reset mid-CALC clears everything at once, no done pulse afterwards
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_q",     bus.quotient, 0);
    check("abort_r",     bus.remainder, 0);
    check("abort_flags", W'({bus.busy, bus.done, bus.div_zero}), 0);
    check("abort_state", W'(dbg_state), W'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("abort_no_done", W'(done_seen), 0);

    run("u9_3",      1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; all data ports scale with it.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1, 1 = two's-complement DIV, 0 = DIVU; sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH, numerator; sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH, denominator; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while a division is in progress or completing.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-010 The block SHALL have port quotient, output, WIDTH, registered quotient (LO), held until the next completion.
REQ-011 The block SHALL have port remainder, output, WIDTH, registered remainder (HI), held until the next completion.
REQ-012 The block SHALL have port div_zero, output, 1, registered flag set when the completed operation had divisor == 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; busy = (state != IDLE); done = (state == DONE).
REQ-014 In IDLE with start=1 at edge T, the block SHALL latch operands and is_signed, clear the iteration counter, and enter CALC.
REQ-015 In CALC, the block SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then enter DONE.
REQ-016 quotient, remainder and div_zero SHALL update on the edge entering DONE, so done is high in cycle T+WIDTH+1 (33 cycles after the start edge for WIDTH=32).
REQ-017 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-018 start SHALL be ignored while busy=1, including in DONE; back-to-back operation is possible from the IDLE cycle after DONE.
REQ-019 Signed mode SHALL divide magnitudes; the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign (truncation toward zero, MIPS semantics).
REQ-020 Signed mode with dividend = most-negative and divisor = -1 SHALL yield quotient = most-negative and remainder = 0, with no trap.
REQ-021 When divisor == 0, the block SHALL take full latency and then give quotient = all-ones, remainder = the original dividend, and div_zero = 1, overriding the sign fix-up.
REQ-022 Operand inputs SHALL NOT affect an operation in progress after the start edge.

Reset
REQ-023 On rst=1, immediately and asynchronously: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, and all internal registers cleared.
REQ-024 Reset during CALC or DONE SHALL abort the operation with no done pulse; the first start after reset is released SHALL be accepted normally.

Structure
REQ-025 State encodings and the default WIDTH SHALL live in the shared CPU definitions package/header.
REQ-026 One sub-module, div_step, SHALL implement the combinational single restoring iteration (partial remainder and quotient bit in; next partial remainder and quotient bit out); div_unit instantiates it once.

Verification
REQ-027 Test unsigned 100 / 7: expect quotient = 14, remainder = 2, div_zero = 0, with done exactly 33 cycles after the start edge and busy high throughout.
REQ-028 Test signed -7 / 2: expect quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Test signed 7 / -2: expect quotient = 0xFFFFFFFD, remainder = 1.
REQ-029 Test 0x80000000 / 0xFFFFFFFF: signed expects quotient = 0x80000000, remainder = 0; unsigned expects quotient = 0, remainder = 0x80000000.
REQ-030 Test 5 / 0, both modes: expect quotient = 0xFFFFFFFF, remainder = 5, div_zero = 1, at normal latency.
REQ-031 Assert start with new operands 10 cycles into CALC: they are ignored and the original result is delivered. Then assert rst mid-CALC: all outputs go to 0 at once, with no done pulse. Then 9 / 3 yields quotient = 3, remainder = 0.
